// File: rtl/router_fifo_pkg.sv
// Shared constants for the router output FIFO: geometry, header marker bit
// and the location of the payload-length field inside a header byte.
package router_fifo_pkg;

   localparam int FIFO_DEPTH = 16;   // storage words
   localparam int FIFO_WIDTH = 9;    // {header marker, data byte}
   localparam int FIFO_ADDR  = 5;    // log2(depth) address bits + wrap bit
   localparam int HDR_BIT    = 8;    // header marker position in a stored word
   localparam int LEN_MSB    = 7;    // payload length field, upper bit
   localparam int LEN_LSB    = 2;    // payload length field, lower bit
   localparam int CNT_W      = 7;    // packet counter width, holds up to 64

   // Bytes still to drain after a header: payload length plus the parity byte.
   function automatic logic [CNT_W-1:0] pkt_remaining(input logic [FIFO_WIDTH-1:0] word);
      return {1'b0, word[LEN_MSB:LEN_LSB]} + CNT_W'(1);
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Output-side packet FIFO of the 1x3 router. Stores bytes tagged with a
// header marker, delivers them with one cycle of read latency, and tracks how
// many bytes of the current packet remain so the output bus can float (Z)
// once the packet has been fully drained. soft_reset flushes a timed-out port.
module router_fifo
   import router_fifo_pkg::*;
#(
   parameter int DEPTH    = FIFO_DEPTH,
   parameter int WIDTH    = FIFO_WIDTH,
   parameter int ADD_SIZE = FIFO_ADDR
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-2:0] datain,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-2:0] dataout
);

   localparam int AW = ADD_SIZE - 1;   // index bits below the wrap bit

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [WIDTH-1:0]    mem_d [DEPTH];
   logic [ADD_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADD_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-2:0]    data_q, data_d;
   logic                oe_q, oe_d;      // 1 = drive dataout, 0 = bus released

   logic                do_wr;
   logic                do_rd;
   logic [WIDTH-1:0]    rd_word;

   // Flags come straight from the pointers; the wrap bit separates full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADD_SIZE-1] != rd_ptr_q[ADD_SIZE-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_wr   = write_enb && !full;
   assign do_rd   = read_enb && !empty;
   assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

   // Output bus floats whenever no packet byte is being presented.
   assign dataout = oe_q ? data_q : 'z;

   // Next-state for storage, pointers, packet counter and output register.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      oe_d     = oe_q;

      if (soft_reset) begin
         // Flush wins over any read or write presented in the same cycle.
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         data_d   = '0;
         oe_d     = 1'b0;
      end else begin
         if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = {lfd_state, datain};
            wr_ptr_d                = wr_ptr_q + ADD_SIZE'(1);
         end

         if (do_rd) begin
            data_d   = rd_word[HDR_BIT-1:0];
            oe_d     = 1'b1;
            rd_ptr_d = rd_ptr_q + ADD_SIZE'(1);
            if (rd_word[HDR_BIT]) begin
               cnt_d = pkt_remaining(rd_word);
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end else if (cnt_q == '0) begin
            // Packet fully drained: release the bus, keep the last byte latched.
            oe_d = 1'b0;
         end
      end
   end

   // State registers; hard reset drives 8'h00 onto the bus rather than Z.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         oe_q     <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         oe_q     <= oe_d;
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: reset, fill/overflow,
// header-driven drain, simultaneous read/write, soft_reset flush, wrap-around.
module tb_router_fifo;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] datain = 8'h00;
   wire        full;
   wire        empty;
   wire  [7:0] dataout;

   int total = 0;
   int bad   = 0;

   logic [7:0] zz = 8'hzz;

   router_fifo dut (
      .clk        (clk),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .datain     (datain),
      .full       (full),
      .empty      (empty),
      .dataout    (dataout)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      resetn     = 1'b1;
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      lfd_state  = 1'b0;
      datain     = 8'h00;
      cyc();
      cyc();
      resetn = 1'b0;
      #1;
   endtask

   function automatic logic [7:0] fill_byte(input int i);
      return 8'(49 + 7 * i);
   endfunction

   task automatic test_reset();
      hard_reset();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      total++; if (dataout !== 8'h00) begin bad++; $display("FAIL reset_dataout got=%h exp=00", dataout); end
      cyc();
      total++; if (dataout !== zz) begin bad++; $display("FAIL reset_idle_z got=%h exp=zz", dataout); end
      $display("reset: empty=%b full=%b dataout=%h", empty, full, dataout);
   endtask

   task automatic test_fill_overflow();
      hard_reset();
      write_enb = 1'b1;
      lfd_state = 1'b1;
      for (int i = 0; i < 17; i++) begin
         datain = fill_byte(i);
         cyc();
         $display("fill wr[%0d] data=%h full=%b", i, datain, full);
         total++;
         if (full !== (i >= 15)) begin
            bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i >= 15));
         end
      end
      write_enb = 1'b0;
      read_enb  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc();
         $display("fill rd[%0d] data=%h", i, dataout);
         total++;
         if (dataout !== fill_byte(i)) begin
            bad++; $display("FAIL fill_rd[%0d] got=%h exp=%h", i, dataout, fill_byte(i));
         end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_empty got=%b exp=1", empty); end
      // Read while empty is ignored; counter is nonzero, so the last byte holds.
      cyc();
      total++; if (dataout !== fill_byte(15)) begin bad++; $display("FAIL fill_rd_empty got=%h exp=%h", dataout, fill_byte(15)); end
      read_enb = 1'b0;
   endtask

   task automatic test_packet();
      logic [7:0] pkt [5];
      pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h0C;
      hard_reset();
      write_enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         lfd_state = (i == 0);
         datain    = pkt[i];
         cyc();
         $display("pkt wr[%0d] data=%h", i, datain);
      end
      write_enb = 1'b0;
      lfd_state = 1'b0;
      total++; if (dataout !== zz) begin bad++; $display("FAIL pkt_idle_z got=%h exp=zz", dataout); end
      read_enb = 1'b1;
      cyc();
      total++; if (dataout !== 8'h0C) begin bad++; $display("FAIL pkt_hdr got=%h exp=0c", dataout); end
      cyc();
      total++; if (dataout !== 8'h11) begin bad++; $display("FAIL pkt_p0 got=%h exp=11", dataout); end
      read_enb = 1'b0;
      cyc();
      total++; if (dataout !== 8'h11) begin bad++; $display("FAIL pkt_hold got=%h exp=11", dataout); end
      read_enb = 1'b1;
      cyc();
      total++; if (dataout !== 8'h22) begin bad++; $display("FAIL pkt_p1 got=%h exp=22", dataout); end
      cyc();
      total++; if (dataout !== 8'h33) begin bad++; $display("FAIL pkt_p2 got=%h exp=33", dataout); end
      cyc();
      total++; if (dataout !== 8'h0C) begin bad++; $display("FAIL pkt_parity got=%h exp=0c", dataout); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL pkt_empty got=%b exp=1", empty); end
      read_enb = 1'b0;
      cyc();
      total++; if (dataout !== zz) begin bad++; $display("FAIL pkt_release got=%h exp=zz", dataout); end
      $display("pkt: drained, dataout=%h", dataout);
   endtask

   task automatic test_simultaneous();
      hard_reset();
      write_enb = 1'b1;
      for (int i = 0; i < 16; i++) begin
         lfd_state = (i == 15);
         datain    = 8'(8'h40 + i);
         cyc();
      end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL sim_full got=%b exp=1", full); end
      // At full: read proceeds, write of EE is dropped.
      lfd_state = 1'b0;
      datain    = 8'hEE;
      read_enb  = 1'b1;
      cyc();
      $display("sim rd+wr at full data=%h", dataout);
      total++; if (dataout !== 8'h40) begin bad++; $display("FAIL sim_full_rd got=%h exp=40", dataout); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL sim_full_after got=%b exp=0", full); end
      write_enb = 1'b0;
      for (int i = 1; i < 16; i++) begin
         cyc();
         total++;
         if (dataout !== 8'(8'h40 + i)) begin
            bad++; $display("FAIL sim_drain[%0d] got=%h exp=%h", i, dataout, 8'(8'h40 + i));
         end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL sim_empty got=%b exp=1", empty); end
      // At empty: write stored, read ignored; last word was a header so output holds.
      write_enb = 1'b1;
      datain    = 8'h5A;
      cyc();
      $display("sim rd+wr at empty data=%h empty=%b", dataout, empty);
      total++; if (dataout !== 8'h4F) begin bad++; $display("FAIL sim_empty_hold got=%h exp=4f", dataout); end
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL sim_empty_after got=%b exp=0", empty); end
      write_enb = 1'b0;
      cyc();
      total++; if (dataout !== 8'h5A) begin bad++; $display("FAIL sim_empty_rd got=%h exp=5a", dataout); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL sim_empty_final got=%b exp=1", empty); end
      read_enb = 1'b0;
   endtask

   task automatic test_soft_reset();
      hard_reset();
      write_enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         datain = 8'(8'h51 + i);
         cyc();
      end
      write_enb = 1'b0;
      read_enb  = 1'b1;
      cyc();
      total++; if (dataout !== 8'h51) begin bad++; $display("FAIL srst_rd0 got=%h exp=51", dataout); end
      cyc();
      total++; if (dataout !== 8'h52) begin bad++; $display("FAIL srst_rd1 got=%h exp=52", dataout); end
      // Flush with read and write also requested: flush must win.
      soft_reset = 1'b1;
      write_enb  = 1'b1;
      datain     = 8'h77;
      cyc();
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      $display("srst: empty=%b full=%b dataout=%h", empty, full, dataout);
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL srst_empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL srst_full got=%b exp=0", full); end
      total++; if (dataout !== zz) begin bad++; $display("FAIL srst_dataout got=%h exp=zz", dataout); end
      write_enb = 1'b1;
      datain    = 8'h99;
      cyc();
      write_enb = 1'b0;
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL srst_wr_empty got=%b exp=0", empty); end
      read_enb = 1'b1;
      cyc();
      read_enb = 1'b0;
      total++; if (dataout !== 8'h99) begin bad++; $display("FAIL srst_rd got=%h exp=99", dataout); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL srst_rd_empty got=%b exp=1", empty); end
   endtask

   task automatic test_wrap();
      hard_reset();
      for (int r = 0; r < 3; r++) begin
         write_enb = 1'b1;
         for (int i = 0; i < 16; i++) begin
            datain = 8'(8'h60 + r * 16 + i);
            cyc();
            total++;
            if (full !== (i == 15)) begin
               bad++; $display("FAIL wrap_full[%0d][%0d] got=%b exp=%b", r, i, full, (i == 15));
            end
         end
         write_enb = 1'b0;
         read_enb  = 1'b1;
         for (int i = 0; i < 16; i++) begin
            cyc();
            $display("wrap rd[%0d][%0d] data=%h", r, i, dataout);
            total++;
            if (dataout !== 8'(8'h60 + r * 16 + i)) begin
               bad++; $display("FAIL wrap_rd[%0d][%0d] got=%h exp=%h", r, i, dataout, 8'(8'h60 + r * 16 + i));
            end
            total++;
            if (empty !== (i == 15)) begin
               bad++; $display("FAIL wrap_empty[%0d][%0d] got=%b exp=%b", r, i, empty, (i == 15));
            end
         end
         read_enb = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_packet();
      test_simultaneous();
      test_soft_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
